// File: rtl/instruction_sequencer.sv
// Program sequencer: issues buffered {op,sel,data} opcodes to the Excutor one at a time with a Done handshake.
// Define SEQ_TIMEOUT_EN to build the WAIT watchdog that raises Error and halts when Done never arrives.
module instruction_sequencer #(
  parameter int AW      = 4,
  parameter int IW      = 20,
  parameter int TIMEOUT = 255
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          LoadEn,
  input  logic [AW-1:0] LoadAddr,
  input  logic [IW-1:0] LoadData,
  input  logic          Start,
  input  logic          ExDone,
  output logic [IW-1:0] OpCode,
  output logic          Busy,
  output logic          Halted,
  output logic          Error,
  output logic [AW-1:0] PC,
  output logic [7:0]    IssueCount
);
  localparam int DEPTH = 2**AW;
  localparam logic [AW-1:0] PC_ONE  = AW'(1);
  localparam logic [AW-1:0] PC_LAST = AW'(DEPTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_GAP, S_HALT} state_t;

  state_t        r_state, w_state_next;
  logic [IW-1:0] r_buf [DEPTH];
  logic [IW-1:0] r_rd_data;
  logic [IW-1:0] r_opcode;
  logic          r_rd_valid;
  logic          r_error;
  logic [AW-1:0] r_pc;
  logic [7:0]    r_issue_cnt;
  logic          w_busy, w_halted;
  logic          w_start_ok, w_wr_en, w_op_zero, w_pc_last, w_timeout;

  assign w_start_ok = Start && (r_state == S_IDLE || r_state == S_HALT);
  assign w_wr_en    = LoadEn && !w_busy;
  assign w_op_zero  = (r_rd_data[IW-1 -: 4] == 4'd0);
  assign w_pc_last  = (r_pc == PC_LAST);

`ifdef SEQ_TIMEOUT_EN
  logic [7:0] r_wdog;

  // Holds 0 outside WAIT, so it reads k-1 during the k-th WAIT cycle.
  always_ff @(posedge Clock) begin
    if (Reset || r_state != S_WAIT) r_wdog <= '0;
    else                            r_wdog <= r_wdog + 8'd1;
  end

  assign w_timeout = (r_state == S_WAIT) && !ExDone && (r_wdog == 8'(TIMEOUT - 1));
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT != 0);
  assign w_timeout        = 1'b0;
`endif

  always_ff @(posedge Clock) begin
    if (Reset) r_state <= S_IDLE;
    else       r_state <= w_state_next;
  end

  // FETCH spends its first cycle on the registered buffer read and decides on the second.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE, S_HALT: if (w_start_ok) w_state_next = S_FETCH;
      S_FETCH:        if (r_rd_valid) w_state_next = w_op_zero ? S_HALT : S_WAIT;
      S_WAIT: begin
        if (ExDone)         w_state_next = S_GAP;
        else if (w_timeout) w_state_next = S_HALT;
      end
      S_GAP:          if (!ExDone) w_state_next = w_pc_last ? S_HALT : S_FETCH;
      default:        w_state_next = S_IDLE;
    endcase
  end

  always_comb begin
    w_busy   = (r_state == S_FETCH) || (r_state == S_WAIT) || (r_state == S_GAP);
    w_halted = (r_state == S_HALT);
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      for (int i = 0; i < DEPTH; i++) r_buf[i] <= '0;
    end else if (w_wr_en) begin
      r_buf[LoadAddr] <= LoadData;
    end
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      r_rd_data   <= '0;
      r_rd_valid  <= 1'b0;
      r_pc        <= '0;
      r_issue_cnt <= '0;
      r_opcode    <= '0;
      r_error     <= 1'b0;
    end else begin
      r_rd_data  <= r_buf[r_pc];
      r_rd_valid <= (r_state == S_FETCH);

      if (w_start_ok) begin
        r_pc        <= '0;
        r_issue_cnt <= '0;
        r_error     <= 1'b0;
      end else if (r_state == S_GAP && !ExDone && !w_pc_last) begin
        r_pc <= r_pc + PC_ONE;
      end

      if (r_state == S_WAIT && ExDone && r_issue_cnt != 8'hFF)
        r_issue_cnt <= r_issue_cnt + 8'd1;

      if (w_timeout) r_error <= 1'b1;

      if (r_state == S_FETCH && r_rd_valid && !w_op_zero)
        r_opcode <= r_rd_data;
      else if (w_state_next != S_WAIT)
        r_opcode <= '0;
    end
  end

  assign OpCode     = r_opcode;
  assign Busy       = w_busy;
  assign Halted     = w_halted;
  assign Error      = r_error;
  assign PC         = r_pc;
  assign IssueCount = r_issue_cnt;
endmodule

// File: tb/tb_instruction_sequencer.sv
// Self-checking bench for instruction_sequencer: directed scenarios plus randomized programs
// checked against a program-level model of which opcodes should issue and where the PC stops.
module tb_instruction_sequencer;
  localparam int AW    = 4;
  localparam int IW    = 20;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          LoadEn;
  logic [AW-1:0] LoadAddr;
  logic [IW-1:0] LoadData;
  logic          Start;
  logic          ExDone;
  logic [IW-1:0] OpCode;
  logic          Busy;
  logic          Halted;
  logic          Error;
  logic [AW-1:0] PC;
  logic [7:0]    IssueCount;

  int total = 0;
  int bad   = 0;
  logic [IW-1:0] m_buf [DEPTH];

  instruction_sequencer #(.AW(AW), .IW(IW), .TIMEOUT(10)) dut (
    .Clock(clk), .Reset(rst), .LoadEn(LoadEn), .LoadAddr(LoadAddr), .LoadData(LoadData),
    .Start(Start), .ExDone(ExDone), .OpCode(OpCode), .Busy(Busy), .Halted(Halted),
    .Error(Error), .PC(PC), .IssueCount(IssueCount)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $display("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      $error("check %s", tag);
    end
  endtask

  task automatic load(input int addr, input logic [IW-1:0] data);
    @(negedge clk);
    LoadEn = 1'b1; LoadAddr = addr[AW-1:0]; LoadData = data;
    @(negedge clk);
    LoadEn = 1'b0;
    m_buf[addr] = data;
  endtask

  task automatic pulse_start();
    @(negedge clk); Start = 1'b1;
    @(negedge clk); Start = 1'b0;
  endtask

  task automatic wait_issue(input string tag);
    int n = 0;
    while (OpCode == '0 && n < 50) begin
      @(negedge clk); n++;
    end
    check(tag, 32'(OpCode != '0), 32'd1);
  endtask

  // Runs a program to HALT acting as the Excutor; expectations come from m_buf only.
  task automatic exec(input bit do_start, input bit do_load, input int la, input logic [IW-1:0] ld,
                      input int dmin, input int dmax, input int hmin, input int hmax);
    logic [IW-1:0] exp_q[$];
    logic [IW-1:0] held;
    int exp_pc, k, cyc, first_cyc, d, h;
    if (do_start) begin
      @(negedge clk);
      Start = 1'b1;
      if (do_load) begin
        LoadEn = 1'b1; LoadAddr = la[AW-1:0]; LoadData = ld;
        m_buf[la] = ld;
      end
      @(negedge clk);
      Start = 1'b0; LoadEn = 1'b0;
    end
    exp_q.delete();
    exp_pc = DEPTH - 1;
    for (int i = 0; i < DEPTH; i++) begin
      if (m_buf[i][19:16] == 4'd0) begin exp_pc = i; break; end
      exp_q.push_back(m_buf[i]);
    end
    k = 0; cyc = 0; first_cyc = -1;
    while (!Halted && cyc < 3000) begin
      if (OpCode != '0) begin
        if (first_cyc < 0) first_cyc = cyc;
        held = OpCode;
        $display("txn %0d opcode=%05h pc=%0d", k, held, PC);
        if (k < exp_q.size()) check("opcode", 32'(held), 32'(exp_q[k]));
        else                  check("extra_issue", 32'(k), 32'(exp_q.size()));
        d = int'($urandom_range(dmax, dmin));
        repeat (d) begin @(negedge clk); check("opcode_hold", 32'(OpCode), 32'(held)); end
        ExDone = 1'b1;
        @(negedge clk);
        check("gap_zero", 32'(OpCode), 32'd0);
        h = int'($urandom_range(hmax, hmin));
        repeat (h) begin @(negedge clk); check("gap_hold", 32'(OpCode), 32'd0); end
        ExDone = 1'b0;
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    check("halted", 32'(Halted), 32'd1);
    check("issued", 32'(k), 32'(exp_q.size()));
    check("final_pc", 32'(PC), 32'(exp_pc));
    check("issue_count", 32'(IssueCount), 32'((k > 255) ? 255 : k));
    check("busy_at_halt", 32'(Busy), 32'd0);
    check("opcode_at_halt", 32'(OpCode), 32'd0);
    check("error_at_halt", 32'(Error), 32'd0);
    if (do_start && exp_q.size() > 0) check("first_latency", 32'(first_cyc), 32'd2);
  endtask

  initial begin
    for (int i = 0; i < DEPTH; i++) m_buf[i] = '0;
    rst = 1'b1; LoadEn = 1'b0; LoadAddr = '0; LoadData = '0; Start = 1'b0; ExDone = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_opcode", 32'(OpCode), 32'd0);
    check("rst_pc", 32'(PC), 32'd0);
    check("rst_count", 32'(IssueCount), 32'd0);
    check("rst_busy", 32'(Busy), 32'd0);
    check("rst_halted", 32'(Halted), 32'd0);
    check("rst_error", 32'(Error), 32'd0);
    rst = 1'b0;

    // Two-opcode program halting on a zero op field, Done 3 cycles after issue.
    load(0, 20'h102AA); load(1, 20'h1014A); load(2, 20'h00000);
    exec(1'b1, 1'b0, 0, '0, 3, 3, 0, 0);

    // Full buffer: halts at the last entry without wrapping.
    for (int i = 0; i < DEPTH; i++) load(i, 20'h30107);
    exec(1'b1, 1'b0, 0, '0, 0, 2, 0, 1);

    // Done held high 5 cycles after each completion.
    load(3, 20'h00000);
    exec(1'b1, 1'b0, 0, '0, 1, 1, 5, 5);

    // Load and Start in the same cycle: the new entry 0 must be the first issued.
    exec(1'b1, 1'b1, 0, 20'h7ABCD, 0, 1, 0, 1);

    // LoadEn and Start while busy are both ignored.
    load(0, 20'h50103); load(1, 20'h20202); load(2, 20'h0FFFF);
    pulse_start();
    wait_issue("busy_issue");
    LoadEn = 1'b1; LoadAddr = 4'd1; LoadData = 20'h50101; Start = 1'b1;
    @(negedge clk);
    LoadEn = 1'b0; Start = 1'b0;
    check("busy_start_opcode", 32'(OpCode), 32'h50103);
    check("busy_start_pc", 32'(PC), 32'd0);
    check("busy_flag", 32'(Busy), 32'd1);
    exec(1'b0, 1'b0, 0, '0, 0, 2, 0, 2);

    // Reset while waiting on the second opcode.
    load(0, 20'h11111); load(1, 20'h50103); load(2, 20'h00000);
    pulse_start();
    wait_issue("rst_first_issue");
    ExDone = 1'b1; @(negedge clk); ExDone = 1'b0;
    wait_issue("rst_second_issue");
    check("pre_rst_opcode", 32'(OpCode), 32'h50103);
    check("pre_rst_pc", 32'(PC), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check("mid_rst_opcode", 32'(OpCode), 32'd0);
    check("mid_rst_pc", 32'(PC), 32'd0);
    check("mid_rst_busy", 32'(Busy), 32'd0);
    check("mid_rst_count", 32'(IssueCount), 32'd0);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) m_buf[i] = '0;
    exec(1'b1, 1'b0, 0, '0, 0, 1, 0, 1);

    // Done never arrives.
    load(0, 20'h50103);
    pulse_start();
    wait_issue("wd_issue");
`ifdef SEQ_TIMEOUT_EN
    repeat (9) @(negedge clk);
    check("wd_pre_error", 32'(Error), 32'd0);
    check("wd_pre_halted", 32'(Halted), 32'd0);
    check("wd_pre_opcode", 32'(OpCode), 32'h50103);
    @(negedge clk);
    check("wd_error", 32'(Error), 32'd1);
    check("wd_halted", 32'(Halted), 32'd1);
    check("wd_opcode", 32'(OpCode), 32'd0);
    check("wd_count", 32'(IssueCount), 32'd0);
    pulse_start();
    check("wd_error_clear", 32'(Error), 32'd0);
    exec(1'b0, 1'b0, 0, '0, 0, 1, 0, 1);
`else
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (c % 50 == 49) begin
        check("nowd_opcode", 32'(OpCode), 32'h50103);
        check("nowd_error", 32'(Error), 32'd0);
        check("nowd_busy", 32'(Busy), 32'd1);
      end
    end
    exec(1'b0, 1'b0, 0, '0, 0, 0, 0, 0);
`endif

    // Randomized programs, including zero op fields with nonzero sel/data.
    for (int it = 0; it < 8; it++) begin
      int len;
      len = int'($urandom_range(16, 0));
      for (int i = 0; i < DEPTH; i++) begin
        logic [IW-1:0] w;
        w = 20'($urandom);
        if (i < len) w[19:16] = 4'($urandom_range(15, 1));
        else if (i == len) w[19:16] = 4'd0;
        load(i, w);
      end
      exec(1'b1, (it == 3), 0, 20'h9_00_01, 0, 4, 0, 3);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
